// File: rtl/knn_ctrl.sv
// rtl/knn_ctrl.sv - KNN sequencer and sorted K-nearest selector; optional perf counters via KNN_CTRL_PERF_EN
module knn_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NBR_KNN   = 4,
    parameter int NBR_TESTP = 4,
    parameter int NBR_DATAP = 10,
    parameter int TI_W      = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1,
    parameter int DI_W      = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1,
    parameter int RK_W      = (NBR_KNN > 1) ? $clog2(NBR_KNN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [TI_W-1:0]   test_addr,
    output logic [DI_W-1:0]   data_addr,
    input  logic [DATA_W-1:0] dist_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TI_W-1:0]   res_test,
    output logic [RK_W-1:0]   res_rank,
    output logic              res_hit,
    output logic [DI_W-1:0]   res_idx,
`ifdef KNN_CTRL_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic [DATA_W-1:0] res_dist
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [TI_W-1:0] I_LAST = TI_W'(NBR_TESTP - 1);
    localparam logic [DI_W-1:0] J_LAST = DI_W'(NBR_DATAP - 1);
    localparam logic [RK_W-1:0] R_LAST = RK_W'(NBR_KNN - 1);

    state_t state, state_nx;

    logic [TI_W-1:0]   i_q;
    logic [DI_W-1:0]   j_q;
    logic [RK_W-1:0]   r_q;
    logic              pend_v;
    logic [DI_W-1:0]   pend_j;

    logic [NBR_KNN-1:0] ent_v;
    logic [DATA_W-1:0]  ent_d [NBR_KNN];
    logic [DI_W-1:0]    ent_i [NBR_KNN];

    logic [NBR_KNN-1:0] nx_v;
    logic [DATA_W-1:0]  nx_d  [NBR_KNN];
    logic [DI_W-1:0]    nx_i  [NBR_KNN];
    logic [NBR_KNN-1:0] le;

    logic last_beat;
    logic list_clr;

    assign last_beat = (state == S_OUT) && res_ready && (r_q == R_LAST);
    assign list_clr  = ((state == S_IDLE) && start) || (last_beat && (i_q != I_LAST));

    // The list is kept sorted with valid entries packed at the front, so le is a
    // prefix mask and the insertion slot is the first entry where it drops to 0.
    genvar k;
    generate
        for (k = 0; k < NBR_KNN; k++) begin : g_ins
            assign le[k] = ent_v[k] && (ent_d[k] <= dist_in);
            if (k == 0) begin : g_head
                always_comb begin
                    nx_v[k] = 1'b1;
                    nx_d[k] = dist_in;
                    nx_i[k] = pend_j;
                    if (le[k]) begin
                        nx_v[k] = ent_v[k];
                        nx_d[k] = ent_d[k];
                        nx_i[k] = ent_i[k];
                    end
                end
            end else begin : g_tail
                always_comb begin
                    nx_v[k] = ent_v[k-1];
                    nx_d[k] = ent_d[k-1];
                    nx_i[k] = ent_i[k-1];
                    if (le[k]) begin
                        nx_v[k] = ent_v[k];
                        nx_d[k] = ent_d[k];
                        nx_i[k] = ent_i[k];
                    end else if (le[k-1]) begin
                        nx_v[k] = 1'b1;
                        nx_d[k] = dist_in;
                        nx_i[k] = pend_j;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            i_q    <= '0;
            j_q    <= '0;
            r_q    <= '0;
            pend_v <= 1'b0;
            pend_j <= '0;
            ent_v  <= '0;
            for (int n = 0; n < NBR_KNN; n++) begin
                ent_d[n] <= '0;
                ent_i[n] <= '0;
            end
        end else begin
            state  <= state_nx;
            pend_v <= rd_en;
            pend_j <= j_q;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_q <= '0;
                        j_q <= '0;
                        r_q <= '0;
                    end
                end
                S_RUN: begin
                    if (j_q != J_LAST) begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_q <= '0;
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (r_q != R_LAST) begin
                            r_q <= r_q + 1'b1;
                        end else if (i_q != I_LAST) begin
                            i_q <= i_q + 1'b1;
                            j_q <= '0;
                            r_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
            if (list_clr) begin
                ent_v <= '0;
            end else if (pend_v) begin
                ent_v <= nx_v;
                for (int n = 0; n < NBR_KNN; n++) begin
                    ent_d[n] <= nx_d[n];
                    ent_i[n] <= nx_i[n];
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        res_test  = '0;
        res_rank  = '0;
        res_hit   = 1'b0;
        res_idx   = '0;
        res_dist  = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                rd_en = 1'b1;
                if (j_q == J_LAST) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                res_test  = i_q;
                res_rank  = r_q;
                res_hit   = ent_v[r_q];
                res_idx   = ent_v[r_q] ? ent_i[r_q] : '1;
                res_dist  = ent_v[r_q] ? ent_d[r_q] : '1;
                if (last_beat) begin
                    state_nx = (i_q == I_LAST) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign test_addr = i_q;
    assign data_addr = j_q;

`ifdef KNN_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
                perf_cycles <= perf_cycles + 1'b1;
            end
            if ((state == S_OUT) && !res_ready && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule
